// File: rtl/serial_chunk_adder_pkg.sv
// Shared definitions for the serial chunk adder: FSM encoding and chunk width.
package serial_chunk_adder_pkg;

  localparam int unsigned CHUNK_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_chunk_adder_rca6.sv
// 6-bit ripple-carry adder built from two chained 3-bit ripple-carry adders.

// 3-bit ripple-carry adder.
module RCA3 (
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic       Cin,
  output logic [2:0] S,
  output logic       Cout
);

  // Bitwise full-adder ripple.
  always_comb begin
    logic [3:0] c;
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int unsigned i = 0; i < 3; i++) begin
      S[i]     = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[3];
  end

endmodule

// 6-bit ripple-carry adder: low RCA3 carries into high RCA3.
module RCA6 (
  input  logic [5:0] A,
  input  logic [5:0] B,
  input  logic       Cin,
  output logic [5:0] S,
  output logic       Cout
);

  logic mid_c;

  RCA3 u_lo (
    .A    (A[2:0]),
    .B    (B[2:0]),
    .Cin  (Cin),
    .S    (S[2:0]),
    .Cout (mid_c)
  );

  RCA3 u_hi (
    .A    (A[5:3]),
    .B    (B[5:3]),
    .Cin  (mid_c),
    .S    (S[5:3]),
    .Cout (Cout)
  );

endmodule

// File: rtl/serial_chunk_adder.sv
// Sequential wide adder: feeds one 6-bit chunk pair per cycle (LSB first)
// through RCA6, collecting the sum chunks and a registered carry chain.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int unsigned CHUNKS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CHUNK_W*CHUNKS-1:0] a_in,
  input  logic [CHUNK_W*CHUNKS-1:0] b_in,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [CHUNK_W*CHUNKS-1:0] sum,
  output logic                      cout
);

  localparam int unsigned N     = CHUNK_W * CHUNKS;
  localparam int unsigned IDX_W = $clog2(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_e             state_q, state_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [N-1:0]       sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CHUNK_W-1:0] rca_a, rca_b, rca_s;
  logic               rca_cout;

  // Select the current chunk pair for the adder.
  always_comb begin
    rca_a = '0;
    rca_b = '0;
    for (int unsigned k = 0; k < CHUNKS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        rca_a = a_q[k*CHUNK_W +: CHUNK_W];
        rca_b = b_q[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  RCA6 u_rca6 (
    .A    (rca_a),
    .B    (rca_b),
    .Cin  (carry_q),
    .S    (rca_s),
    .Cout (rca_cout)
  );

  // Next-state, operand latch, write-back and registered-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end
      end
      ADD: begin
        for (int unsigned k = 0; k < CHUNKS; k++) begin
          if (idx_q == IDX_W'(k)) begin
            sum_d[k*CHUNK_W +: CHUNK_W] = rca_s;
          end
        end
        carry_d = rca_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = rca_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they are registered.
    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench for serial_chunk_adder (CHUNKS=4, N=24) against a
// plain-arithmetic reference model {cout,sum} = a + b + cin.
module tb_serial_chunk_adder;

  localparam int unsigned CH = 4;
  localparam int unsigned NW = 24;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [NW-1:0] a_in;
  logic [NW-1:0] b_in;
  logic          cin;
  logic          busy;
  logic          done;
  logic [NW-1:0] sum;
  logic          cout;

  int total = 0;
  int bad   = 0;

  serial_chunk_adder #(.CHUNKS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Issue one operation and check latency, busy, clearing, result and hold.
  task automatic run_op(input string tag, input logic [NW-1:0] a,
                        input logic [NW-1:0] b, input logic c);
    logic [NW:0] expv;
    int cycles;
    expv = {1'b0, a} + {1'b0, b} + {{NW{1'b0}}, c};
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = NW'($urandom); b_in = NW'($urandom); cin = 1'($urandom);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_clr"}, 64'({cout, sum}), 64'd0);
    cycles = 0;
    while (!done && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, "_lat"}, 64'(cycles), 64'(CH));
    check({tag, "_res"}, 64'({cout, sum}), 64'(expv));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'({busy, done}), 64'd0);
    check({tag, "_hold"}, 64'({cout, sum}), 64'(expv));
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;

    // Reset state while clock toggles.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 64'({busy, done, cout, sum}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("basic", 24'd16, 24'd17, 1'b0);
    run_op("intra", 24'd63, 24'd60, 1'b0);
    check("intra_c0", 64'(sum[5:0]), 64'h3B);
    check("intra_c1", 64'(sum[11:6]), 64'h01);
    run_op("ripple", 24'hFFFFFF, 24'h000001, 1'b0);
    run_op("allone", 24'hFFFFFF, 24'hFFFFFF, 1'b1);

    // Start while busy: second request at T2 must be dropped.
    @(negedge clk);
    a_in = 24'd8; b_in = 24'd7; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;           // T0
    @(posedge clk); #1;                          // T1
    @(negedge clk); a_in = 24'd1; b_in = 24'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;            // T2
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        check("busy_res", 64'({cout, sum}), 64'd15);
      end
    end
    check("busy_pulses", 64'(pulses), 64'd1);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    a_in = 24'hFFFFFF; b_in = 24'd1; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;            // T0
    @(posedge clk); #1;                          // T1
    @(posedge clk); #1;                          // T2
    rst_n = 1'b0;
    #1;
    check("midrst_out", 64'({busy, done, cout, sum}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("midrst_idle", 64'(pulses), 64'd0);
    run_op("after_rst", 24'd16, 24'd17, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 20; i++) begin
      run_op("rand", NW'($urandom), NW'($urandom), 1'($urandom));
    end

    // Back-to-back: start held high is accepted again at T(CH+2).
    @(negedge clk);
    a_in = 24'd100; b_in = 24'd200; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;                          // T0
    a_in = 24'd5; b_in = 24'd6; cin = 1'b0;
    repeat (CH + 1) @(posedge clk);              // T(CH+1): back in IDLE
    #1;
    check("b2b_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;                          // T(CH+2): accepted
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    repeat (CH) @(posedge clk);
    #1;
    check("b2b_res", 64'({done, cout, sum}), 64'({1'b1, 25'd11}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
